instruction_memory_responder: RTL and testbench
===============================================

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_0040_0000, which is the byte address of word 0 and the fetch reset PC.
REQ-002 SHALL have parameter DEPTH_WORDS, default 63 (252 bytes), which is the number of 32-bit instruction words held.
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0013, which is the fill and error-response instruction.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the fetch request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 SHALL have port req_pc, input, 64 bits: the requested byte address.
REQ-009 SHALL have port rsp_valid, output, 1 bit: the response is present.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer takes the response this cycle.
REQ-011 SHALL have port rsp_instruction, output, 32 bits: the fetched word.
REQ-012 SHALL have port rsp_pc, output, 64 bits: the echo of the accepted req_pc.
REQ-013 SHALL have port rsp_error, output, 2 bits: 00 ok, 01 misaligned, 10 out-of-range.
REQ-014 SHALL have port ld_en, input, 1 bit: the program-load write strobe.
REQ-015 SHALL have port ld_index, input, 6 bits: the word index for the load.
REQ-016 SHALL have port ld_data, input, 32 bits: the load word.
REQ-017 SHALL have port fetch_count, output, 16 bits: the number of accepted requests, saturating.

Function
REQ-018 SHALL implement a two-state FSM: IDLE (rsp_valid=0) and RESP (rsp_valid=1).
REQ-019 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally, so that back-to-back requests sustain one per cycle.
REQ-020 SHALL, on handshake (req_valid && req_ready), register a response for presentation the next cycle: a latency of exactly 1 cycle.
REQ-021 SHALL go from IDLE to RESP on handshake, and from RESP to IDLE when rsp_ready=1 and there is no new handshake; RESP with rsp_ready=1 and a new handshake SHALL stay in RESP with the new data.
REQ-022 SHALL hold rsp_instruction, rsp_pc and rsp_error stable while rsp_valid && !rsp_ready.
REQ-023 SHALL compute offset = req_pc - BASE_ADDR with 64-bit wrap, and word index = offset[7:2].
REQ-024 SHALL give misaligned (req_pc[1:0] != 0) priority over out-of-range (offset >= DEPTH_WORDS*4, unsigned; a PC below the base wraps and is out-of-range).
REQ-025 SHALL, on error, return rsp_instruction = NOP_WORD; the memory SHALL NOT be read for that response.
REQ-026 SHALL, when ld_en=1, write ld_data to word ld_index at posedge; ld_index >= DEPTH_WORDS SHALL be ignored.
REQ-027 SHALL, when a load and a handshake target the same word in the same cycle, return the old word (read-before-write).
REQ-028 SHALL increment fetch_count on every handshake, including error responses, and saturate it at 16'hFFFF.

Reset
REQ-029 SHALL, while reset=0 (asynchronously), set state IDLE, rsp_valid=0, rsp_instruction=NOP_WORD, rsp_pc=0, rsp_error=00, fetch_count=0, and every memory word to NOP_WORD.
REQ-030 SHALL discard any pending response if reset is asserted mid-response; req_ready SHALL be 1 in the first cycle after deassertion.
REQ-031 SHALL ignore ld_en while reset=0.

Structure
REQ-032 SHALL take the rsp_error code constants (OK/MISALIGNED/OUT_OF_RANGE), the FSM state encoding, NOP_WORD and the BASE_ADDR default from the shared riscv package.
REQ-033 SHALL place the storage in one sub-module, instr_mem_array (synchronous write port, asynchronous read port, reset fill); the handshake and FSM logic SHALL stay in the top.

Verification
REQ-034 SHALL have a bench scenario: load index 0 = 32'h0000_0030, then request PC 64'h40_0000 -> one cycle later rsp_valid=1, rsp_instruction=32'h30, rsp_pc=64'h40_0000, rsp_error=00.
REQ-035 SHALL have a bench scenario: request PC 64'h40_0002 -> rsp_error=01, rsp_instruction=32'h13; request PC 64'h40_00FC -> rsp_error=10; request PC 64'h3F_FFFC -> rsp_error=10.
REQ-036 SHALL have a bench scenario: request with rsp_ready=0 for 3 cycles -> req_ready=0 and outputs stable for 3 cycles; then rsp_ready=1 with a new request -> the next response appears the following cycle with no bubble.
REQ-037 SHALL have a bench scenario: load index 5 = 32'hAAAA_AAAA while requesting PC 64'h40_0014 in the same cycle -> response is 32'h13; repeating the request -> response is 32'hAAAA_AAAA.
REQ-038 SHALL have a bench scenario: assert reset while rsp_valid=1 -> rsp_valid=0 immediately, without waiting for a clock edge, and fetch_count=0; after release, reading any index -> 32'h13.
REQ-039 SHALL have a bench scenario: preload fetch_count near its limit (force or 65535 requests) -> fetch_count holds at 16'hFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: response codes, fetch FSM encoding and
// the default instruction-memory constants.
package riscv_pkg;

    localparam logic [63:0] IMEM_BASE_ADDR_DEFAULT = 64'h0000_0000_0040_0000;
    localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;

    typedef enum logic [1:0] {
        RSP_OK           = 2'b00,
        RSP_MISALIGNED   = 2'b01,
        RSP_OUT_OF_RANGE = 2'b10
    } rsp_err_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous
// read port, every word filled with the NOP instruction on reset.
module instr_mem_array
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 63,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_index,
    input  logic [31:0] wr_data,
    input  logic [5:0]  rd_index,
    output logic [31:0] rd_data
);

    localparam logic [6:0] DEPTH_L = 7'(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_d [DEPTH_WORDS];

    // Writes beyond the populated depth are dropped rather than aliased.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_index} < DEPTH_L)) begin
            mem_d[wr_index] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = ({1'b0, rd_index} < DEPTH_L) ? mem_q[rd_index] : NOP_WORD;

endmodule

// File: rtl/instruction_memory_responder.sv
// Instruction fetch responder: valid/ready request and response channels with
// one-cycle latency, address checking and a saturating fetch counter.
module instruction_memory_responder
    import riscv_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = IMEM_BASE_ADDR_DEFAULT,
    parameter int          DEPTH_WORDS = 63,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instruction,
    output logic [63:0] rsp_pc,
    output logic [1:0]  rsp_error,
    input  logic        ld_en,
    input  logic [5:0]  ld_index,
    input  logic [31:0] ld_data,
    output logic [15:0] fetch_count
);

    localparam logic [63:0] LIMIT_BYTES = 64'(DEPTH_WORDS * 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  rsp_instruction_q, rsp_instruction_d;
    logic [63:0]  rsp_pc_q, rsp_pc_d;
    rsp_err_e     rsp_error_q, rsp_error_d;
    logic [15:0]  fetch_count_q, fetch_count_d;

    logic [63:0]  offset;
    logic [31:0]  rd_data;
    logic         handshake;
    logic         misaligned;
    logic         out_of_range;

    // A PC below the base wraps to a huge offset and so lands out of range.
    assign offset       = req_pc - BASE_ADDR;
    assign misaligned   = (req_pc[1:0] != 2'b00);
    assign out_of_range = (offset >= LIMIT_BYTES);

    assign rsp_valid = (state_q == ST_RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign handshake = req_valid && req_ready;

    instr_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .NOP_WORD    (NOP_WORD)
    ) u_mem (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (ld_en),
        .wr_index (ld_index),
        .wr_data  (ld_data),
        .rd_index (offset[7:2]),
        .rd_data  (rd_data)
    );

    // The read samples the array before this edge's load, giving old data on a collision.
    always_comb begin
        state_d           = state_q;
        rsp_instruction_d = rsp_instruction_q;
        rsp_pc_d          = rsp_pc_q;
        rsp_error_d       = rsp_error_q;
        fetch_count_d     = fetch_count_q;
        if (handshake) begin
            state_d       = ST_RESP;
            rsp_pc_d      = req_pc;
            fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
            if (misaligned) begin
                rsp_error_d       = RSP_MISALIGNED;
                rsp_instruction_d = NOP_WORD;
            end else if (out_of_range) begin
                rsp_error_d       = RSP_OUT_OF_RANGE;
                rsp_instruction_d = NOP_WORD;
            end else begin
                rsp_error_d       = RSP_OK;
                rsp_instruction_d = rd_data;
            end
        end else if (rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            rsp_instruction_q <= NOP_WORD;
            rsp_pc_q          <= 64'd0;
            rsp_error_q       <= RSP_OK;
            fetch_count_q     <= 16'd0;
        end else begin
            state_q           <= state_d;
            rsp_instruction_q <= rsp_instruction_d;
            rsp_pc_q          <= rsp_pc_d;
            rsp_error_q       <= rsp_error_d;
            fetch_count_q     <= fetch_count_d;
        end
    end

    assign rsp_instruction = rsp_instruction_q;
    assign rsp_pc          = rsp_pc_q;
    assign rsp_error       = rsp_error_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Directed bench for instruction_memory_responder with hand-computed expectations.
module tb_instruction_memory_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instruction;
    logic [63:0] rsp_pc;
    logic [1:0]  rsp_error;
    logic        ld_en;
    logic [5:0]  ld_index;
    logic [31:0] ld_data;
    logic [15:0] fetch_count;

    int compared;
    int mismatched;

    instruction_memory_responder dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_instruction (rsp_instruction),
        .rsp_pc          (rsp_pc),
        .rsp_error       (rsp_error),
        .ld_en           (ld_en),
        .ld_index        (ld_index),
        .ld_data         (ld_data),
        .fetch_count     (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResponse(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic [1:0] err);
        checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        checkOutput({tag, "_instr"}, 64'(rsp_instruction), 64'(instr));
        checkOutput({tag, "_pc"}, rsp_pc, pc);
        checkOutput({tag, "_err"}, 64'(rsp_error), 64'(err));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_pc     = 64'd0;
        rsp_ready  = 1'b1;
        ld_en      = 1'b1;
        ld_index   = 6'd0;
        ld_data    = 32'hDEAD_BEEF;

        // Reset state, with a load strobe that must be ignored
        tick();
        tick();
        checkOutput("rst_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_instr", 64'(rsp_instruction), 64'h13);
        checkOutput("rst_pc", rsp_pc, 64'd0);
        checkOutput("rst_err", 64'(rsp_error), 64'd0);
        checkOutput("rst_count", 64'(fetch_count), 64'd0);
        reset = 1'b1;
        ld_en = 1'b0;

        req_valid = 1'b1;
        req_pc    = 64'h40_0000;
        tick();
        checkResponse("ldrst", 32'h13, 64'h40_0000, 2'b00);
        req_valid = 1'b0;
        tick();
        checkOutput("idle1_valid", 64'(rsp_valid), 64'd0);

        // Basic load then fetch
        ld_en    = 1'b1;
        ld_index = 6'd0;
        ld_data  = 32'h0000_0030;
        tick();
        ld_en     = 1'b0;
        req_valid = 1'b1;
        req_pc    = 64'h40_0000;
        tick();
        checkResponse("basic", 32'h30, 64'h40_0000, 2'b00);
        checkOutput("basic_count", 64'(fetch_count), 64'd2);

        // Back-to-back error responses and the last valid word
        req_pc = 64'h40_0002;
        tick();
        checkResponse("misal", 32'h13, 64'h40_0002, 2'b01);
        req_pc = 64'h40_00FC;
        tick();
        checkResponse("oor_top", 32'h13, 64'h40_00FC, 2'b10);
        req_pc = 64'h3F_FFFC;
        tick();
        checkResponse("oor_below", 32'h13, 64'h3F_FFFC, 2'b10);
        req_pc = 64'h40_00F8;
        tick();
        checkResponse("last_word", 32'h13, 64'h40_00F8, 2'b00);
        checkOutput("err_count", 64'(fetch_count), 64'd6);
        req_valid = 1'b0;
        tick();
        checkOutput("idle2_valid", 64'(rsp_valid), 64'd0);

        // Backpressure for three cycles, then a bubble-free follow-on
        ld_en    = 1'b1;
        ld_index = 6'd3;
        ld_data  = 32'h1234_5678;
        tick();
        ld_en     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 64'h40_000C;
        tick();
        checkResponse("bp_first", 32'h1234_5678, 64'h40_000C, 2'b00);
        req_pc = 64'h40_0010;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_ready", 64'(req_ready), 64'd0);
            tick();
            checkResponse("bp_hold", 32'h1234_5678, 64'h40_000C, 2'b00);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(req_ready), 64'd1);
        tick();
        checkResponse("bp_next", 32'h13, 64'h40_0010, 2'b00);
        checkOutput("bp_count", 64'(fetch_count), 64'd8);
        req_valid = 1'b0;
        tick();

        // Load and fetch of the same word in one cycle
        ld_en     = 1'b1;
        ld_index  = 6'd5;
        ld_data   = 32'hAAAA_AAAA;
        req_valid = 1'b1;
        req_pc    = 64'h40_0014;
        tick();
        checkResponse("rbw_old", 32'h13, 64'h40_0014, 2'b00);
        ld_en = 1'b0;
        tick();
        checkResponse("rbw_new", 32'hAAAA_AAAA, 64'h40_0014, 2'b00);
        checkOutput("rbw_count", 64'(fetch_count), 64'd10);

        // Asynchronous reset in the middle of a response
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(rsp_valid), 64'd0);
        checkOutput("arst_count", 64'(fetch_count), 64'd0);
        tick();
        reset = 1'b1;
        checkOutput("arst_ready", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pc    = 64'h40_0014;
        tick();
        checkResponse("arst_w5", 32'h13, 64'h40_0014, 2'b00);
        req_pc = 64'h40_0000;
        tick();
        checkResponse("arst_w0", 32'h13, 64'h40_0000, 2'b00);
        checkOutput("arst_count2", 64'(fetch_count), 64'd2);

        // Saturation of the fetch counter
        for (int i = 0; i < 65532; i++) begin
            tick();
        end
        checkOutput("sat_fffe", 64'(fetch_count), 64'hFFFE);
        tick();
        checkOutput("sat_ffff", 64'(fetch_count), 64'hFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checkOutput("sat_hold", 64'(fetch_count), 64'hFFFF);
        req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
